fp_mant_left_normalizer: RTL and testbench

- Sequential post-operation normalizer for half-precision datapath results.
- Takes an unnormalized 11-bit mantissa (hidden bit at bit 10) with its 5-bit biased exponent.
- Shifts the mantissa left until the MSB is set or the exponent floor is reached, decrementing the exponent as it goes.
- Sits between the add/sub mantissa core and the rounding/pack stage. It is the left-direction counterpart of the existing right-shift mantissa path.

---
 rtl/fp_norm_pkg.sv | 20 ++
 rtl/fp_norm_step.sv | 40 ++++
 rtl/fp_mant_left_normalizer.sv | 137 +++++++++++++
 tb/tb_fp_mant_left_normalizer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared constants, types and FSM encoding for the half-precision mantissa left normalizer.
package fp_norm_pkg;
  localparam int DEF_MANT_W = 11;
  localparam int DEF_EXP_W  = 5;

  typedef logic [DEF_MANT_W-1:0] mant_t;
  typedef logic [DEF_EXP_W-1:0]  exp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Debug view of the controller: current state plus the subnormal-input flag.
  typedef struct packed {
    state_t state;
    logic   sub_in;
  } dbg_t;
endpackage

// File: rtl/fp_norm_step.sv
// One normalization step: next mantissa/exponent/shift count and a stop flag.
// Defining FP_NORM_FAST_STEP_EN enables a 4-bit stride when it cannot overshoot.
module fp_norm_step #(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 5
) (
  input  logic [MANT_W-1:0] i_mant,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [EXP_W-1:0]  i_shamt,
  output logic [MANT_W-1:0] o_mant,
  output logic [EXP_W-1:0]  o_exp,
  output logic [EXP_W-1:0]  o_shamt,
  output logic              o_stop
);
  logic w_fast;

  assign o_stop = i_mant[MANT_W-1] || (i_exp == EXP_W'(1));

`ifdef FP_NORM_FAST_STEP_EN
  // Four top zeros and exp>=5 means four single steps would all be taken anyway.
  assign w_fast = (i_mant[MANT_W-1:MANT_W-4] == 4'b0000) && (i_exp >= EXP_W'(5));
`else
  assign w_fast = 1'b0;
`endif

  always_comb begin
    o_mant  = i_mant;
    o_exp   = i_exp;
    o_shamt = i_shamt;
    if (w_fast) begin
      o_mant  = {i_mant[MANT_W-5:0], 4'b0000};
      o_exp   = i_exp - EXP_W'(4);
      o_shamt = i_shamt + EXP_W'(4);
    end else begin
      o_mant  = {i_mant[MANT_W-2:0], 1'b0};
      o_exp   = i_exp - EXP_W'(1);
      o_shamt = i_shamt + EXP_W'(1);
    end
  end
endmodule

// File: rtl/fp_mant_left_normalizer.sv
// Sequential left normalizer: IDLE -> SHIFT -> DONE, one operand in flight.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// Optional macro FP_NORM_FAST_STEP_EN (in fp_norm_step) shortens latency only.
module fp_mant_left_normalizer
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = DEF_MANT_W,
  parameter int EXP_W  = DEF_EXP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_shamt,
  output logic              out_zero,
  output dbg_t              o_dbg
);
  state_t            r_state;
  logic              r_sign;
  logic              r_sub_in;
  logic [MANT_W-1:0] r_mant;
  logic [EXP_W-1:0]  r_exp;
  logic [EXP_W-1:0]  r_shamt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_sign;
  logic [EXP_W-1:0]  r_out_exp;
  logic [MANT_W-1:0] r_out_mant;
  logic [EXP_W-1:0]  r_out_shamt;
  logic              r_out_zero;

  logic [MANT_W-1:0] w_nxt_mant;
  logic [EXP_W-1:0]  w_nxt_exp;
  logic [EXP_W-1:0]  w_nxt_shamt;
  logic              w_stop;

  fp_norm_step #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_step (
    .i_mant  (r_mant),
    .i_exp   (r_exp),
    .i_shamt (r_shamt),
    .o_mant  (w_nxt_mant),
    .o_exp   (w_nxt_exp),
    .o_shamt (w_nxt_shamt),
    .o_stop  (w_stop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_sub_in    <= 1'b0;
      r_mant      <= '0;
      r_exp       <= '0;
      r_shamt     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_exp   <= '0;
      r_out_mant  <= '0;
      r_out_shamt <= '0;
      r_out_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign     <= in_sign;
            r_mant     <= in_mant;
            // Subnormal inputs carry an arithmetic exponent of 1.
            r_exp      <= (in_exp == '0) ? EXP_W'(1) : in_exp;
            r_sub_in   <= (in_exp == '0);
            r_shamt    <= '0;
            r_in_ready <= 1'b0;
            if (in_mant == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_out_sign  <= in_sign;
              r_out_exp   <= '0;
              r_out_mant  <= '0;
              r_out_shamt <= '0;
              r_out_zero  <= 1'b1;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (w_stop) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_sign  <= r_sign;
            r_out_exp   <= r_mant[MANT_W-1] ? r_exp : '0;
            r_out_mant  <= r_mant;
            r_out_shamt <= r_shamt;
            r_out_zero  <= 1'b0;
          end else begin
            r_mant  <= w_nxt_mant;
            r_exp   <= w_nxt_exp;
            r_shamt <= w_nxt_shamt;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_sign     = r_out_sign;
  assign out_exp      = r_out_exp;
  assign out_mant     = r_out_mant;
  assign out_shamt    = r_out_shamt;
  assign out_zero     = r_out_zero;
  assign o_dbg.state  = r_state;
  assign o_dbg.sub_in = r_sub_in;
endmodule

// File: tb/tb_fp_mant_left_normalizer.sv
// Table-driven bench with an expected-result queue for fp_mant_left_normalizer.
module tb_fp_mant_left_normalizer;
  import fp_norm_pkg::*;

  localparam int PW = 1 + DEF_EXP_W + DEF_MANT_W + DEF_EXP_W + 1;

  typedef struct {
    logic  sign;
    exp_t  exp;
    mant_t mant;
    mant_t r_mant;
    exp_t  r_exp;
    exp_t  r_shamt;
    logic  r_zero;
    int    lat_slow;
    int    lat_fast;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid;
  logic  in_ready;
  logic  in_sign;
  exp_t  in_exp;
  mant_t in_mant;
  logic  out_valid;
  logic  out_ready;
  logic  out_sign;
  exp_t  out_exp;
  mant_t out_mant;
  exp_t  out_shamt;
  logic  out_zero;
  dbg_t  dbg;

  logic [PW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[11];

  fp_mant_left_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_shamt (out_shamt),
    .out_zero  (out_zero),
    .o_dbg     (dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pk(input logic s, input exp_t e, input mant_t m,
                                       input exp_t sh, input logic z);
    return {s, e, m, sh, z};
  endfunction

  function automatic logic [PW-1:0] dut_pk();
    return {out_sign, out_exp, out_mant, out_shamt, out_zero};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drive_accept(input logic s, input exp_t e, input mant_t m,
                              input logic [PW-1:0] expected);
    int n;
    @(negedge clk);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back(expected);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int lat, output logic [PW-1:0] got_exp);
    int n;
    n = 0;
    got_exp = '0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_latency"}, 32'(n), 32'(lat));
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      got_exp = exp_q.pop_front();
      check({name, "_result"}, 32'(dut_pk()), 32'(got_exp));
    end
  endtask

  task automatic release_result(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic int lat_of(input vec_t v);
`ifdef FP_NORM_FAST_STEP_EN
    return v.lat_fast;
`else
    return v.lat_slow;
`endif
  endfunction

  initial begin
    logic [PW-1:0] e;

    vecs[0]  = '{1'b1, 5'd15, 11'h400, 11'h400, 5'd15, 5'd0,  1'b0, 1,  1};
    vecs[1]  = '{1'b0, 5'd20, 11'h001, 11'h400, 5'd10, 5'd10, 1'b0, 11, 5};
    vecs[2]  = '{1'b0, 5'd3,  11'h010, 11'h040, 5'd0,  5'd2,  1'b0, 3,  3};
    vecs[3]  = '{1'b0, 5'd12, 11'h000, 11'h000, 5'd0,  5'd0,  1'b1, 0,  0};
    vecs[4]  = '{1'b1, 5'd0,  11'h001, 11'h001, 5'd0,  5'd0,  1'b0, 1,  1};
    vecs[5]  = '{1'b0, 5'd31, 11'h7ff, 11'h7ff, 5'd31, 5'd0,  1'b0, 1,  1};
    vecs[6]  = '{1'b1, 5'd8,  11'h0ff, 11'h7f8, 5'd5,  5'd3,  1'b0, 4,  4};
    vecs[7]  = '{1'b0, 5'd11, 11'h001, 11'h400, 5'd1,  5'd10, 1'b0, 11, 5};
    vecs[8]  = '{1'b0, 5'd1,  11'h080, 11'h080, 5'd0,  5'd0,  1'b0, 1,  1};
    vecs[9]  = '{1'b0, 5'd4,  11'h001, 11'h008, 5'd0,  5'd3,  1'b0, 4,  4};
    vecs[10] = '{1'b1, 5'd6,  11'h003, 11'h060, 5'd0,  5'd5,  1'b0, 6,  3};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'(dut_pk()), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive_accept(vecs[i].sign, vecs[i].exp, vecs[i].mant,
                   pk(vecs[i].sign, vecs[i].r_exp, vecs[i].r_mant, vecs[i].r_shamt, vecs[i].r_zero));
      wait_result($sformatf("vec%0d", i), lat_of(vecs[i]), e);
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles while a new operand waits upstream.
    drive_accept(1'b0, 5'd20, 11'h001, pk(1'b0, 5'd10, 11'h400, 5'd10, 1'b0));
    wait_result("bp", lat_of(vecs[1]), e);
    @(negedge clk);
    in_sign  = 1'b1;
    in_exp   = 5'd9;
    in_mant  = 11'h200;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", c), 32'(dut_pk()), 32'(e));
      check($sformatf("bp_in_ready%0d", c), 32'(in_ready), 32'd0);
      check($sformatf("bp_valid%0d", c), 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(pk(1'b1, 5'd8, 11'h400, 5'd1, 1'b0));
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_held_accepted", 32'(in_ready), 32'd0);
    wait_result("bp_held", 2, e);
    release_result("bp_held");

    // Asynchronous reset in the middle of SHIFT aborts the operation.
    drive_accept(1'b0, 5'd20, 11'h001, pk(1'b0, 5'd10, 11'h400, 5'd10, 1'b0));
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_state", 32'(dbg.state), 32'(IDLE));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive_accept(1'b0, 5'd9, 11'h200, pk(1'b0, 5'd8, 11'h400, 5'd1, 1'b0));
    wait_result("post_rst", 2, e);
    release_result("post_rst");

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
